perceptron_host_ctrl: RTL and testbench

Host-side initiator for the perceptron UART command protocol. Takes one request at a time (write weights, write inputs, read weights, read result) on a valid/ready interface and serializes it into bytes for a UART transmitter. It parses the board's reply bytes from the UART receiver and returns the result on a one-cycle response strobe. Used in loopback test benches and host-FPGA bridges that drive a perceptron board.

---
 rtl/perceptron_proto_pkg.sv | 51 +++++
 rtl/perceptron_host_timeout.sv | 26 ++
 rtl/perceptron_host_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_perceptron_host_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_proto_pkg.sv
// Shared constants for the perceptron UART command protocol: opcodes, ack byte,
// per-opcode frame lengths, host FSM states and frame byte selection.
package perceptron_proto_pkg;

  localparam logic [1:0] OP_WR_WEIGHTS = 2'd0;
  localparam logic [1:0] OP_WR_INPUTS  = 2'd1;
  localparam logic [1:0] OP_RD_WEIGHTS = 2'd2;
  localparam logic [1:0] OP_RD_RESULT  = 2'd3;

  localparam logic [7:0] ACK_BYTE = 8'hAA;

  localparam logic [2:0] TX_LEN_WR         = 3'd5;
  localparam logic [2:0] TX_LEN_RD         = 3'd1;
  localparam logic [2:0] RX_LEN_WR         = 3'd1;
  localparam logic [2:0] RX_LEN_RD_WEIGHTS = 3'd4;
  localparam logic [2:0] RX_LEN_RD_RESULT  = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT_TX = 3'd3,
    ST_WAIT_RX = 3'd4,
    ST_DONE    = 3'd5
  } host_state_e;

  function automatic logic [2:0] tx_len(input logic [1:0] op);
    return op[1] ? TX_LEN_RD : TX_LEN_WR;
  endfunction

  function automatic logic [2:0] rx_len(input logic [1:0] op);
    case (op)
      OP_RD_WEIGHTS: return RX_LEN_RD_WEIGHTS;
      OP_RD_RESULT:  return RX_LEN_RD_RESULT;
      default:       return RX_LEN_WR;
    endcase
  endfunction

  // Opcode first, then a and b MSB first.
  function automatic logic [7:0] frame_byte(input logic [1:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [2:0] idx);
    case (idx)
      3'd0:    return {6'b0, op};
      3'd1:    return a[15:8];
      3'd2:    return a[7:0];
      3'd3:    return b[15:8];
      default: return b[7:0];
    endcase
  endfunction

endpackage

// File: rtl/perceptron_host_timeout.sv
// Loadable down-counter for the reply timeout; expired_c is high while the count is zero.
module perceptron_host_timeout #(
  parameter int unsigned count_w = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [count_w-1:0] load_value,
  output logic               expired_c
);

  logic [count_w-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - count_w'(1);
    end
  end

  assign expired_c = (count == '0);

endmodule

// File: rtl/perceptron_host_ctrl.sv
// Host-side initiator for the perceptron UART protocol: serializes one request, parses the reply.
// Optional reply timeout enabled by defining PERCEPTRON_HOST_TIMEOUT_EN.
module perceptron_host_ctrl
  import perceptron_proto_pkg::*;
#(
  parameter int unsigned clock_frequency = 12000000,
  parameter int unsigned timeout_ms      = 10,
  parameter logic [7:0]  ack_byte        = ACK_BYTE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  output logic [15:0] rsp_a,
  output logic [15:0] rsp_b,
  output logic        rsp_error,
  output logic [7:0]  uart_byte,
  output logic        uart_send,
  input  logic        uart_busy,
  input  logic [7:0]  rx_byte,
  input  logic        rx_byte_ready,
  output logic        uart_clear,
  output logic [2:0]  host_state
);

  localparam int unsigned timeout_cycles = clock_frequency / 1000 * timeout_ms;

  if (timeout_cycles == 0) begin : g_bad_timeout
    $error("perceptron_host_ctrl: timeout must be at least one cycle");
  end

  host_state_e state, state_n;
  logic [1:0]  op_q, op_n;
  logic [15:0] a_q, a_n, b_q, b_n;
  logic [2:0]  tx_idx, tx_idx_n, rx_idx, rx_idx_n;
  logic        tx_seen, tx_seen_n;
  logic        rx_wait_low, rx_wait_low_n;
  logic [31:0] shift_q, shift_n, shift_next;
  logic [7:0]  uart_byte_n;
  logic        uart_send_n, uart_clear_n, rsp_valid_n, rsp_error_n, req_ready_n;
  logic [15:0] rsp_a_n, rsp_b_n;
  logic        rx_take;

  // A byte is taken once; the next one needs rx_byte_ready to drop first.
  assign rx_take    = rx_byte_ready && !rx_wait_low;
  assign host_state = state;

`ifdef PERCEPTRON_HOST_TIMEOUT_EN
  logic timeout_hit;
  logic tmo_load;

  assign tmo_load = (state != ST_WAIT_RX) || rx_take;

  perceptron_host_timeout #(.count_w(32)) u_timeout (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tmo_load),
    .load_value (32'(timeout_cycles - 1)),
    .expired_c  (timeout_hit)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tx_idx      <= '0;
      rx_idx      <= '0;
      tx_seen     <= 1'b0;
      rx_wait_low <= 1'b0;
      shift_q     <= '0;
      uart_byte   <= '0;
      uart_send   <= 1'b0;
      uart_clear  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_error   <= 1'b0;
      rsp_a       <= '0;
      rsp_b       <= '0;
      req_ready   <= 1'b1;
    end else begin
      state       <= state_n;
      op_q        <= op_n;
      a_q         <= a_n;
      b_q         <= b_n;
      tx_idx      <= tx_idx_n;
      rx_idx      <= rx_idx_n;
      tx_seen     <= tx_seen_n;
      rx_wait_low <= rx_wait_low_n;
      shift_q     <= shift_n;
      uart_byte   <= uart_byte_n;
      uart_send   <= uart_send_n;
      uart_clear  <= uart_clear_n;
      rsp_valid   <= rsp_valid_n;
      rsp_error   <= rsp_error_n;
      rsp_a       <= rsp_a_n;
      rsp_b       <= rsp_b_n;
      req_ready   <= req_ready_n;
    end
  end

  always_comb begin
    state_n       = state;
    op_n          = op_q;
    a_n           = a_q;
    b_n           = b_q;
    tx_idx_n      = tx_idx;
    rx_idx_n      = rx_idx;
    tx_seen_n     = tx_seen;
    rx_wait_low_n = rx_byte_ready ? rx_wait_low : 1'b0;
    shift_n       = shift_q;
    shift_next    = {shift_q[23:0], rx_byte};
    uart_byte_n   = uart_byte;
    uart_send_n   = 1'b0;
    uart_clear_n  = 1'b0;
    rsp_valid_n   = 1'b0;
    rsp_error_n   = rsp_error;
    rsp_a_n       = rsp_a;
    rsp_b_n       = rsp_b;

    // Bytes arriving outside WAIT_RX are stale: consume and drop them.
    if (rx_take && (state inside {ST_IDLE, ST_LOAD, ST_SEND, ST_WAIT_TX})) begin
      uart_clear_n  = 1'b1;
      rx_wait_low_n = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          op_n     = req_op;
          a_n      = req_a;
          b_n      = req_b;
          tx_idx_n = '0;
          rx_idx_n = '0;
          shift_n  = '0;
          state_n  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        uart_byte_n = frame_byte(op_q, a_q, b_q, tx_idx);
        state_n     = ST_SEND;
      end
      ST_SEND: begin
        if (!uart_busy) begin
          uart_send_n = 1'b1;
          tx_seen_n   = 1'b0;
          state_n     = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        if (uart_busy) begin
          tx_seen_n = 1'b1;
        end else if (tx_seen) begin
          if (3'(tx_idx + 3'd1) < tx_len(op_q)) begin
            tx_idx_n = 3'(tx_idx + 3'd1);
            state_n  = ST_LOAD;
          end else begin
            state_n = ST_WAIT_RX;
          end
        end
      end
      ST_WAIT_RX: begin
        if (rx_take) begin
          shift_n       = shift_next;
          uart_clear_n  = 1'b1;
          rx_wait_low_n = 1'b1;
          rx_idx_n      = 3'(rx_idx + 3'd1);
          if (rx_idx_n == rx_len(op_q)) begin
            state_n     = ST_DONE;
            rsp_valid_n = 1'b1;
            rsp_error_n = 1'b0;
            rsp_a_n     = '0;
            rsp_b_n     = '0;
            case (op_q)
              OP_RD_WEIGHTS: begin
                rsp_a_n = shift_next[31:16];
                rsp_b_n = shift_next[15:0];
              end
              OP_RD_RESULT: rsp_a_n = shift_next[15:0];
              default:      rsp_error_n = (rx_byte != ack_byte);
            endcase
          end
        end
`ifdef PERCEPTRON_HOST_TIMEOUT_EN
        else if (timeout_hit) begin
          state_n     = ST_DONE;
          rsp_valid_n = 1'b1;
          rsp_error_n = 1'b1;
          rsp_a_n     = '0;
          rsp_b_n     = '0;
        end
`endif
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    req_ready_n = (state_n == ST_IDLE);
  end

endmodule

// File: tb/tb_perceptron_host_ctrl.sv
// Directed bench for perceptron_host_ctrl with small UART tx/rx models.
module tb_perceptron_host_ctrl;

`ifdef PERCEPTRON_HOST_TIMEOUT_EN
  localparam int unsigned TMO_MS = 1;
`else
  localparam int unsigned TMO_MS = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic        rsp_valid;
  logic [15:0] rsp_a, rsp_b;
  logic        rsp_error;
  logic [7:0]  uart_byte;
  logic        uart_send;
  logic        uart_busy = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        rx_byte_ready = 1'b0;
  logic        uart_clear;
  logic [2:0]  host_state;

  always #5 clk = ~clk;

  perceptron_host_ctrl #(
    .clock_frequency (12000000),
    .timeout_ms      (TMO_MS),
    .ack_byte        (8'hAA)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_a         (req_a),
    .req_b         (req_b),
    .rsp_valid     (rsp_valid),
    .rsp_a         (rsp_a),
    .rsp_b         (rsp_b),
    .rsp_error     (rsp_error),
    .uart_byte     (uart_byte),
    .uart_send     (uart_send),
    .uart_busy     (uart_busy),
    .rx_byte       (rx_byte),
    .rx_byte_ready (rx_byte_ready),
    .uart_clear    (uart_clear),
    .host_state    (host_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int busy_len = 3;
  int bcnt = 0;
  int send_cnt = 0;
  int clr_cnt = 0;
  int rsp_cnt = 0;
  bit sent_while_busy = 1'b0;
  logic [7:0] txq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transmitter model: busy for busy_len cycles after each send; also counts strobes.
  always @(negedge clk) begin
    if (uart_clear) clr_cnt++;
    if (rsp_valid) rsp_cnt++;
    if (uart_send) begin
      if (uart_busy) sent_while_busy = 1'b1;
      txq.push_back(uart_byte);
      send_cnt++;
      uart_busy = 1'b1;
      bcnt = busy_len;
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) uart_busy = 1'b0;
    end
  end

  task automatic start_req(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    int k;
    int lat;
    k = 0;
    lat = -1;
    while (!req_ready && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_before_req", 32'(req_ready), 32'd1);
    txq.delete();
    req_op = op;
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req_valid = 1'b0;
        req_a = 16'hDEAD;
        req_b = 16'hBEEF;
        req_op = ~op;
      end
      if (uart_send && lat < 0) lat = i;
    end
    check("send_latency", 32'(lat), 32'd3);
  endtask

  task automatic wait_rx();
    int k;
    k = 0;
    while (host_state != 3'd4 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("reach_wait_rx", 32'(host_state), 32'd4);
  endtask

  task automatic reply(input logic [7:0] b);
    int k;
    @(negedge clk);
    rx_byte = b;
    rx_byte_ready = 1'b1;
    k = 0;
    while (!uart_clear && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rx_cleared", 32'(uart_clear), 32'd1);
    rx_byte_ready = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                          input logic ee);
    int k;
    k = 0;
    while (!rsp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_a"}, 32'(rsp_a), 32'(ea));
    check({tag, "_b"}, 32'(rsp_b), 32'(eb));
    check({tag, "_err"}, 32'(rsp_error), 32'(ee));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic check_tx(input string tag, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b);
    logic [7:0] exp[5];
    int n;
    exp[0] = {6'b0, op};
    exp[1] = a[15:8];
    exp[2] = a[7:0];
    exp[3] = b[15:8];
    exp[4] = b[7:0];
    n = op[1] ? 1 : 5;
    check({tag, "_txlen"}, 32'(txq.size()), 32'(n));
    for (int i = 0; i < n && i < txq.size(); i++) check({tag, "_txbyte"}, 32'(txq[i]), 32'(exp[i]));
  endtask

  initial begin
    int c0;
    int r0;
    int s0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_uart_send", 32'(uart_send), 32'd0);
    check("rst_uart_clear", 32'(uart_clear), 32'd0);
    check("rst_state", 32'(host_state), 32'd0);
    check("rst_uart_byte", 32'(uart_byte), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write weights, good ack.
    start_req(2'd0, 16'h1234, 16'hF00D);
    wait_rx();
    check_tx("wrw", 2'd0, 16'h1234, 16'hF00D);
    reply(8'hAA);
    wait_rsp("wrw", 16'h0, 16'h0, 1'b0);

    // Read weights.
    c0 = clr_cnt;
    start_req(2'd2, 16'h0, 16'h0);
    wait_rx();
    check_tx("rdw", 2'd2, 16'h0, 16'h0);
    reply(8'h0A); reply(8'hBC); reply(8'h00); reply(8'h7F);
    wait_rsp("rdw", 16'h0ABC, 16'h007F, 1'b0);
    check("rdw_clears", 32'(clr_cnt - c0), 32'd4);

    // Read result.
    start_req(2'd3, 16'h0, 16'h0);
    wait_rx();
    check_tx("rdr", 2'd3, 16'h0, 16'h0);
    reply(8'h00); reply(8'h01);
    wait_rsp("rdr", 16'h0001, 16'h0, 1'b0);

    // Write inputs, bad ack.
    start_req(2'd1, 16'h0005, 16'h0006);
    wait_rx();
    check_tx("wri", 2'd1, 16'h0005, 16'h0006);
    reply(8'h55);
    wait_rsp("wri", 16'h0, 16'h0, 1'b1);

    // Long transmitter busy: no second send until busy drops.
    busy_len = 100;
    s0 = send_cnt;
    fork
      begin
        start_req(2'd0, 16'hA5A5, 16'h5A5A);
        wait_rx();
        check_tx("busy", 2'd0, 16'hA5A5, 16'h5A5A);
        reply(8'hAA);
        wait_rsp("busy", 16'h0, 16'h0, 1'b0);
      end
      begin
        int k;
        k = 0;
        while (send_cnt == s0 && k < 50) begin
          @(negedge clk);
          k++;
        end
        repeat (50) @(negedge clk);
        check("busy_one_send", 32'(send_cnt - s0), 32'd1);
        check("busy_req_ready", 32'(req_ready), 32'd0);
      end
    join
    check("no_send_while_busy", 32'(sent_while_busy), 32'd0);
    busy_len = 3;

    // Extra byte while idle is consumed without a response.
    c0 = clr_cnt;
    r0 = rsp_cnt;
    reply(8'h77);
    repeat (5) @(negedge clk);
    check("idle_extra_clear", 32'(clr_cnt - c0), 32'd1);
    check("idle_extra_norsp", 32'(rsp_cnt - r0), 32'd0);
    check("idle_extra_state", 32'(host_state), 32'd0);

`ifdef PERCEPTRON_HOST_TIMEOUT_EN
    // No reply: timeout after 12000 cycles in WAIT_RX.
    begin
      int k;
      start_req(2'd3, 16'h0, 16'h0);
      wait_rx();
      k = 0;
      while (!rsp_valid && k < 13000) begin
        @(negedge clk);
        k++;
      end
      check("tmo_cycles", 32'(k), 32'd12000);
      check("tmo_err", 32'(rsp_error), 32'd1);
      check("tmo_a", 32'(rsp_a), 32'd0);
    end
`endif

    // Reset in the middle of WAIT_RX aborts silently.
    start_req(2'd3, 16'h0, 16'h0);
    wait_rx();
    reply(8'h99);
    @(negedge clk);
    rst_n = 1'b0;
    r0 = rsp_cnt;
    repeat (2) @(negedge clk);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_state", 32'(host_state), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_norsp", 32'(rsp_cnt - r0), 32'd0);

    // Clean transaction after the abort.
    start_req(2'd3, 16'h0, 16'h0);
    wait_rx();
    reply(8'h12); reply(8'h34);
    wait_rsp("post", 16'h1234, 16'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
